serdes_sync_fifo: RTL and testbench
===================================

# serdes_sync_fifo

Single-clock, parametrised data FIFO for the SerDes datapath, replacing the 1-bit, externally-pointered memory with a self-contained buffer. It owns its read/write pointers, occupancy counter, status flags and sticky error flags. It sits between the deserialiser word assembler and the downstream framer, and anywhere else a same-clock elastic buffer is needed. Read data is registered by default, with an optional first-word-fall-through mode.

## Interface
Parameters:
- DATA_WIDTH, 8: word width in bits
- DEPTH, 8: number of entries; must be a power of two, at least 2
- PTR_WIDTH, 3: log2(DEPTH); pointers are PTR_WIDTH+1 bits wide
- AFULL_THRESH, 6: o_almost_full asserts when count >= this value
- AEMPTY_THRESH, 2: o_almost_empty asserts when count <= this value

Ports:
- i_Clk  input  1  the only clock; all state updates on its rising edge
- i_Rst  input  1  asynchronous, active-high reset
- i_W_en  input  1  write request
- i_Data_In  input  DATA_WIDTH  write data
- i_R_en  input  1  read (pop) request
- o_Data_Out  output  DATA_WIDTH  read data
- o_rd_valid  output  1  o_Data_Out holds a popped/head word
- o_full  output  1  count == DEPTH
- o_empty  output  1  count == 0
- o_almost_full  output  1  count >= AFULL_THRESH
- o_almost_empty  output  1  count <= AEMPTY_THRESH
- o_count  output  PTR_WIDTH+1  occupancy, 0..DEPTH
- o_overflow  output  1  sticky: a write was attempted while full
- o_underflow  output  1  sticky: a read was attempted while empty

## Operation
- **Write acceptance:** a write is accepted when i_W_en=1 and o_full=0 at the edge.
  - mem[wptr[PTR_WIDTH-1:0]] <= i_Data_In; wptr increments.
- **Read acceptance:** a read is accepted when i_R_en=1 and o_empty=0 at the edge; rptr increments.
- **Flag evaluation:** full and empty are evaluated from the pre-edge count. This gives the following cases:
  - Full with simultaneous read and write: the read is accepted and the write is rejected (overflow sets).
  - Empty with simultaneous read and write: the write is accepted and the read is rejected (underflow sets).
  - Neither full nor empty, both requests: both are accepted and count is unchanged.
- **Count update:** count += accepted write − accepted read.
- **Pointer wrap:** pointers wrap naturally modulo 2·DEPTH. Only the low PTR_WIDTH bits address memory.
- **Status flags:** all flags are pure decodes of the registered count. There is no combinational path from i_W_en/i_R_en to any flag.
- **Error flags:**
  - o_overflow sets on a rejected write; o_underflow sets on a rejected read.
  - Both are cleared only by i_Rst.
  - A rejected request changes no pointer, count or memory.
- **Memory reset:** memory contents are not reset. Pointers, count and the output register are reset.
- **Reset values:** o_Data_Out=0, o_rd_valid=0, o_count=0, o_empty=1, o_full=0, o_almost_empty=1, o_almost_full=0, o_overflow=0, o_underflow=0.
- **Reset during operation:** asserting i_Rst mid-operation discards all contents immediately (asynchronously). The first write after deassertion lands in entry 0.

## Timing
- Write to count: a write accepted at edge N is reflected in o_count/flags after edge N.
- Default (registered) read:
  - A read accepted at edge N loads o_Data_Out with the head word at edge N and pulses o_rd_valid high for the cycle after N.
  - o_Data_Out holds its value when no read is accepted.
- Minimum write-to-read latency: a word written at edge N can be read (accepted) at edge N+1 and appears on o_Data_Out after N+1.
- Throughput: one write and one read per cycle, sustained.

## Configuration
- **SERDES_FIFO_FWFT_EN** defined (first-word-fall-through):
  - o_Data_Out = mem[rptr] combinationally whenever o_empty=0.
  - o_rd_valid = !o_empty.
  - i_R_en acts as an acknowledge that pops the head word at the edge.
  - A word written at edge N is visible on o_Data_Out after edge N.
  - o_Data_Out is don't-care while empty; the bench must not check it.
- **Not defined:** registered read behaviour as described above; no combinational memory read path.

## Test plan
- **Fill and drain:** reset, then write 0x01..0x08 on consecutive cycles, then read 8 times.
  - o_full=1 after the 8th write, o_count=8.
  - Reads return 0x01..0x08 in order, each with o_rd_valid=1.
  - o_empty=1 after the last read.
- **Overflow:** with the FIFO full, write 0xAA.
  - o_overflow=1, o_count stays 8.
  - Subsequent reads return 0x01..0x08; 0xAA never appears.
- **Underflow:** with the FIFO empty, read once.
  - o_underflow=1, o_rd_valid=0, o_count=0.
  - o_underflow stays 1 until i_Rst.
- **Simultaneous read and write at the boundaries:**
  - At count=8: accepted read, rejected write, count becomes 7.
  - At count=0: accepted write, rejected read, count becomes 1.
  - At count=4: count stays 4 for 20 cycles; data order is preserved.
- **Wrap and thresholds:** stream 100 words (0x00..0x63) while keeping count between 1 and 7.
  - All words arrive in order.
  - o_almost_full=1 exactly when count>=6; o_almost_empty=1 exactly when count<=2.
- **Mid-stream reset:** assert i_Rst asynchronously (between edges) with count=5.
  - All outputs take their reset values immediately.
  - After release, write 0x5A and read it: returns 0x5A.
  - Repeat this scenario with SERDES_FIFO_FWFT_EN defined: 0x5A appears on o_Data_Out the cycle after the write.

Source files
------------

// File: rtl/serdes_sync_fifo.sv
// Single-clock elastic FIFO for the SerDes datapath with occupancy count, status and sticky error flags.
// Define SERDES_FIFO_FWFT_EN for first-word-fall-through read data; the default is a registered read.
module serdes_sync_fifo #(
   parameter int DATA_WIDTH    = 8,
   parameter int DEPTH         = 8,
   parameter int PTR_WIDTH     = 3,
   parameter int AFULL_THRESH  = 6,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                  i_Clk,
   input  logic                  i_Rst,
   input  logic                  i_W_en,
   input  logic [DATA_WIDTH-1:0] i_Data_In,
   input  logic                  i_R_en,
   output logic [DATA_WIDTH-1:0] o_Data_Out,
   output logic                  o_rd_valid,
   output logic                  o_full,
   output logic                  o_empty,
   output logic                  o_almost_full,
   output logic                  o_almost_empty,
   output logic [PTR_WIDTH:0]    o_count,
   output logic                  o_overflow,
   output logic                  o_underflow
);

   localparam logic [PTR_WIDTH:0] DEPTH_C  = (PTR_WIDTH+1)'(DEPTH);
   localparam logic [PTR_WIDTH:0] AFULL_C  = (PTR_WIDTH+1)'(AFULL_THRESH);
   localparam logic [PTR_WIDTH:0] AEMPTY_C = (PTR_WIDTH+1)'(AEMPTY_THRESH);
   localparam logic [PTR_WIDTH:0] ONE      = (PTR_WIDTH+1)'(1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_WIDTH:0]    wptr, rptr, count;
   logic                  wr_ok, rd_ok;

   // Flags decode the registered count only, so requests never reach them combinationally.
   assign o_full         = (count == DEPTH_C);
   assign o_empty        = (count == '0);
   assign o_almost_full  = (count >= AFULL_C);
   assign o_almost_empty = (count <= AEMPTY_C);
   assign o_count        = count;

   assign wr_ok = i_W_en & ~o_full;
   assign rd_ok = i_R_en & ~o_empty;

   always_ff @(posedge i_Clk) begin
      if (wr_ok) mem[wptr[PTR_WIDTH-1:0]] <= i_Data_In;
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         wptr        <= '0;
         rptr        <= '0;
         count       <= '0;
         o_overflow  <= 1'b0;
         o_underflow <= 1'b0;
      end else begin
         if (wr_ok) wptr <= wptr + ONE;
         if (rd_ok) rptr <= rptr + ONE;
         unique case ({wr_ok, rd_ok})
            2'b10:   count <= count + ONE;
            2'b01:   count <= count - ONE;
            default: count <= count;
         endcase
         if (i_W_en && o_full)  o_overflow  <= 1'b1;
         if (i_R_en && o_empty) o_underflow <= 1'b1;
      end
   end

`ifdef SERDES_FIFO_FWFT_EN
   assign o_Data_Out = mem[rptr[PTR_WIDTH-1:0]];
   assign o_rd_valid = ~o_empty;
`else
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         o_Data_Out <= '0;
         o_rd_valid <= 1'b0;
      end else begin
         o_rd_valid <= rd_ok;
         if (rd_ok) o_Data_Out <= mem[rptr[PTR_WIDTH-1:0]];
      end
   end
`endif

endmodule

// File: tb/tb_serdes_sync_fifo.sv
// Self-checking bench for serdes_sync_fifo against a queue-based reference model.
// Build with SERDES_FIFO_FWFT_EN defined to exercise the fall-through read mode.
module tb_serdes_sync_fifo;
   localparam int DW = 8;
   localparam int DEPTH = 8;
   localparam int PW = 3;

   logic          i_Clk = 1'b0;
   logic          i_Rst = 1'b1;
   logic          i_W_en = 1'b0;
   logic [DW-1:0] i_Data_In = '0;
   logic          i_R_en = 1'b0;
   logic [DW-1:0] o_Data_Out;
   logic          o_rd_valid, o_full, o_empty, o_almost_full, o_almost_empty;
   logic [PW:0]   o_count;
   logic          o_overflow, o_underflow;

   serdes_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_WIDTH(PW),
                      .AFULL_THRESH(6), .AEMPTY_THRESH(2)) dut (
      .i_Clk(i_Clk), .i_Rst(i_Rst), .i_W_en(i_W_en), .i_Data_In(i_Data_In),
      .i_R_en(i_R_en), .o_Data_Out(o_Data_Out), .o_rd_valid(o_rd_valid),
      .o_full(o_full), .o_empty(o_empty), .o_almost_full(o_almost_full),
      .o_almost_empty(o_almost_empty), .o_count(o_count),
      .o_overflow(o_overflow), .o_underflow(o_underflow));

   always #5 i_Clk = ~i_Clk;

   // Reference model: contents as a queue, plus expected output-register state.
   logic [DW-1:0] q[$];
   logic [DW-1:0] m_dout;
   logic          m_vld, m_ovf, m_udf;
   int            n_chk = 0;
   int            n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_dout = '0;
      m_vld  = 1'b0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
   endtask

   task automatic check_all(input string tag);
      int n;
      n = q.size();
      chk({tag, ".count"}, 32'(o_count), 32'(n));
      chk({tag, ".full"},  32'(o_full),  32'(n == DEPTH));
      chk({tag, ".empty"}, 32'(o_empty), 32'(n == 0));
      chk({tag, ".afull"}, 32'(o_almost_full),  32'(n >= 6));
      chk({tag, ".aempty"}, 32'(o_almost_empty), 32'(n <= 2));
      chk({tag, ".ovf"}, 32'(o_overflow),  32'(m_ovf));
      chk({tag, ".udf"}, 32'(o_underflow), 32'(m_udf));
`ifdef SERDES_FIFO_FWFT_EN
      chk({tag, ".vld"}, 32'(o_rd_valid), 32'(n != 0));
      if (n != 0) chk({tag, ".dout"}, 32'(o_Data_Out), 32'(q[0]));
`else
      chk({tag, ".vld"},  32'(o_rd_valid), 32'(m_vld));
      chk({tag, ".dout"}, 32'(o_Data_Out), 32'(m_dout));
`endif
   endtask

   // One clock: drive requests, take the edge, advance the model, compare.
   task automatic cyc(input string tag, input logic we, input logic [DW-1:0] din, input logic re);
      bit was_full, was_empty;
      i_W_en = we; i_Data_In = din; i_R_en = re;
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      @(posedge i_Clk); #1;
      m_vld = 1'b0;
      if (re && !was_empty) begin m_dout = q.pop_front(); m_vld = 1'b1; end
      if (re && was_empty) m_udf = 1'b1;
      if (we && !was_full) q.push_back(din);
      if (we && was_full) m_ovf = 1'b1;
      i_W_en = 1'b0; i_R_en = 1'b0;
      check_all(tag);
   endtask

   initial begin
      int wcnt;
      logic we, re;
      model_reset();
      #2 check_all("reset");
      #1 i_Rst = 1'b0;

      for (int i = 1; i <= 8; i++) cyc("fill", 1'b1, DW'(i), 1'b0);
      cyc("ovf_wr", 1'b1, 8'hAA, 1'b0);
      for (int i = 0; i < 8; i++) cyc("drain", 1'b0, 8'h00, 1'b1);
      cyc("udf_rd", 1'b0, 8'h00, 1'b1);
      cyc("udf_hold", 1'b0, 8'h00, 1'b0);

      cyc("rw_at0", 1'b1, 8'h11, 1'b1);
      for (int i = 0; i < 7; i++) cyc("refill", 1'b1, DW'(8'h20 + i), 1'b0);
      cyc("rw_at8", 1'b1, 8'hBB, 1'b1);
      for (int i = 0; i < 3; i++) cyc("to4", 1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 20; i++) cyc("rw_at4", 1'b1, DW'(8'h40 + i), 1'b1);

      // Random stream of 0x00..0x63 keeping occupancy within 1..7.
      wcnt = 0;
      while (wcnt < 100) begin
         we = (q.size() < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
         re = (q.size() > 1) ? 1'($urandom_range(0, 1)) : 1'b0;
         cyc("stream", we, DW'(wcnt), re);
         if (we) wcnt++;
      end
      while (q.size() != 0) cyc("flush", 1'b0, 8'h00, 1'b1);

      for (int i = 0; i < 5; i++) cyc("pre_rst", 1'b1, DW'(8'h70 + i), 1'b0);
      #1 i_Rst = 1'b1;
      model_reset();
      #1 check_all("async_rst");
      i_Rst = 1'b0;
      cyc("post_rst_wr", 1'b1, 8'h5A, 1'b0);
      cyc("post_rst_rd", 1'b0, 8'h00, 1'b1);
      cyc("idle", 1'b0, 8'h00, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
